// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - I2C target write receiver with receive FIFO; optional clock stretching via I2C_CLK_STRETCH_EN
module i2c_target_rx #(
   parameter logic [6:0] TARGET_ADDR = 7'h42,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       scl_oe,
   output logic [7:0] rx_data,
   output logic       rx_first,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       bus_busy,
   output logic       stop_pulse,
   output logic       ovf_pulse
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic                   w_scl;
   logic                   w_sda;
   logic                   w_scl_rise;
   logic                   w_scl_fall;
   logic                   w_start;
   logic                   w_stop;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [6:0]             r_shift;
   logic [6:0]             w_shift_nxt;
   logic [2:0]             r_bit_cnt;
   logic [2:0]             w_bit_cnt_nxt;
   logic                   r_ack_on;
   logic                   w_ack_on_nxt;
   logic                   r_sda_oe;
   logic                   w_sda_oe_nxt;
   logic                   r_scl_oe;
   logic                   w_scl_oe_nxt;
   logic                   w_push;
   logic                   w_ovf;
   logic                   w_match;
   logic [7:0]             w_byte;

   logic                   r_first_pending;
   logic                   r_addressed;
   logic                   r_busy;
   logic                   r_stop_pulse;
   logic                   r_ovf_pulse;

   logic [8:0]             r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [CW-1:0]          r_count;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & ~r_sda_d & w_sda;
   assign w_byte     = {r_shift, w_sda};

   assign w_full  = (r_count == DEPTH_C);
   assign w_empty = (r_count == '0);
   assign w_pop   = ~w_empty & rx_ready;

   assign sda_oe     = r_sda_oe;
   assign scl_oe     = r_scl_oe;
   assign rx_valid   = ~w_empty;
   assign rx_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
   assign rx_first   = w_empty ? 1'b0 : r_mem[r_rd_ptr][8];
   assign bus_busy   = r_busy;
   assign stop_pulse = r_stop_pulse;
   assign ovf_pulse  = r_ovf_pulse;

   // Pad synchronisers preset high so leaving reset never looks like a bus edge
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   // Protocol state register and its datapath registers
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_ack_on  <= 1'b0;
         r_sda_oe  <= 1'b0;
         r_scl_oe  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_ack_on  <= w_ack_on_nxt;
         r_sda_oe  <= w_sda_oe_nxt;
         r_scl_oe  <= w_scl_oe_nxt;
      end
   end

   // Next-state logic: bus conditions first, then per-state bit handling
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_ack_on_nxt  = r_ack_on;
      w_sda_oe_nxt  = r_sda_oe;
`ifdef I2C_CLK_STRETCH_EN
      w_scl_oe_nxt  = r_scl_oe;
`else
      w_scl_oe_nxt  = 1'b0;
`endif
      w_push        = 1'b0;
      w_ovf         = 1'b0;
      w_match       = 1'b0;
      if (w_start) begin
         w_state_nxt   = S_ADDR;
         w_bit_cnt_nxt = '0;
         w_ack_on_nxt  = 1'b0;
         w_sda_oe_nxt  = 1'b0;
         w_scl_oe_nxt  = 1'b0;
      end else if (w_stop) begin
         w_state_nxt   = S_IDLE;
         w_ack_on_nxt  = 1'b0;
         w_sda_oe_nxt  = 1'b0;
         w_scl_oe_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
            end
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_byte[6:0];
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     if (w_byte[7:1] == TARGET_ADDR && !w_byte[0]) begin
                        w_match     = 1'b1;
                        w_state_nxt = S_ADDR_ACK;
                     end else begin
                        w_state_nxt = S_IGNORE;
                     end
                  end
               end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
               // First fall drives ACK, the fall ending the 9th clock releases it
               if (w_scl_fall) begin
                  if (!r_ack_on) begin
                     w_sda_oe_nxt = 1'b1;
                     w_ack_on_nxt = 1'b1;
                  end else begin
                     w_sda_oe_nxt  = 1'b0;
                     w_ack_on_nxt  = 1'b0;
                     w_bit_cnt_nxt = '0;
                     w_state_nxt   = S_DATA;
`ifdef I2C_CLK_STRETCH_EN
                     if (w_full) w_scl_oe_nxt = 1'b1;
`endif
                  end
               end
            end
            S_DATA: begin
`ifdef I2C_CLK_STRETCH_EN
               if (r_scl_oe && !w_full) w_scl_oe_nxt = 1'b0;
`endif
               if (w_scl_rise) begin
                  w_shift_nxt   = w_byte[6:0];
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     if (!w_full) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_DATA_ACK;
                     end else begin
`ifndef I2C_CLK_STRETCH_EN
                        w_ovf       = 1'b1;
`endif
                        w_state_nxt = S_IGNORE;
                     end
                  end
               end
            end
            S_IGNORE: begin
               w_sda_oe_nxt = 1'b0;
            end
            default: begin
               w_state_nxt  = S_IDLE;
               w_sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

   // Transaction flags and one-cycle status pulses
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_first_pending <= 1'b0;
         r_addressed     <= 1'b0;
         r_busy          <= 1'b0;
         r_stop_pulse    <= 1'b0;
         r_ovf_pulse     <= 1'b0;
      end else begin
         r_stop_pulse <= w_stop & r_addressed;
         r_ovf_pulse  <= w_ovf;
         if (w_start) begin
            r_busy          <= 1'b1;
            r_addressed     <= 1'b0;
            r_first_pending <= 1'b1;
         end else if (w_stop) begin
            r_busy          <= 1'b0;
            r_addressed     <= 1'b0;
         end else begin
            if (w_match) r_addressed     <= 1'b1;
            if (w_push)  r_first_pending <= 1'b0;
         end
      end
   end

   // FIFO storage; entries carry {first, byte}
   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_first_pending, w_byte};
   end

   // FIFO pointers and occupancy; simultaneous push and pop both take effect
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
